// File: rtl/gearbox_pkg.sv
// Shared types and constants for the gearbox sequence controller:
// FSM state encoding, special gear codes and active-low 7-segment patterns.
package gearbox_pkg;

    typedef enum logic [1:0] {
        S_NEUTRAL = 2'd0,
        S_DRIVE   = 2'd1,
        S_BRAKING = 2'd2,
        S_REVERSE = 2'd3
    } state_t;

    localparam logic [3:0] GEAR_N = 4'd0;
    localparam logic [3:0] GEAR_R = 4'd15;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Map a gear code onto its display pattern; unknown codes blank the digit
    function automatic logic [6:0] seg_code(input logic [3:0] gear_code);
        logic [6:0] code;
        case (gear_code)
            4'd0:    code = SEG_N;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            4'd15:   code = SEG_R;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability counter: the output level
// only flips once the synchronised input has differed from it for
// DEBOUNCE_CYC consecutive enabled cycles.
module input_debounce #(
    parameter int DEBOUNCE_CYC = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw button and count consecutive samples that disagree with the level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (ena) begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/gearbox_seq_ctrl.sv
// Sequential gearbox controller: debounced up/down/brake buttons drive a
// neutral/drive/braking/reverse FSM with a post-shift dwell lockout,
// timed automatic downshifts while braking and a registered 7-seg display.
module gearbox_seq_ctrl
    import gearbox_pkg::*;
#(
    parameter int NUM_GEARS      = 5,
    parameter int DEBOUNCE_CYC   = 250,
    parameter int HOLD_CYC       = 2500,
    parameter int BRAKE_STEP_CYC = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       shift_up,
    input  logic       shift_down,
    input  logic       brake,
    output logic [3:0] gear,
    output logic [6:0] segments,
    output logic       shift_event,
    output logic       reject
);

    localparam int DWELL_W = $clog2(HOLD_CYC + 1);
    localparam int STEP_W  = $clog2(BRAKE_STEP_CYC + 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(HOLD_CYC);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(BRAKE_STEP_CYC - 1);
    localparam logic [3:0]         TOP_GEAR   = 4'(NUM_GEARS);

    logic               up_lvl_s, down_lvl_s, brake_lvl_s;
    logic               up_prev_r, down_prev_r;
    logic               up_pulse_s, down_pulse_s, manual_s, both_s, dwell_busy_s;
    logic               legal_s;
    state_t             state_r;
    logic [3:0]         gear_r;
    logic [6:0]         segments_r;
    logic               shift_event_r, reject_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [STEP_W-1:0]  step_r;

    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(shift_up), .level(up_lvl_s)
    );
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(shift_down), .level(down_lvl_s)
    );
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_brake (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(brake), .level(brake_lvl_s)
    );

    assign up_pulse_s   = up_lvl_s & ~up_prev_r;
    assign down_pulse_s = down_lvl_s & ~down_prev_r;
    assign manual_s     = up_pulse_s | down_pulse_s;
    assign both_s       = up_pulse_s & down_pulse_s;
    assign dwell_busy_s = (dwell_r != {DWELL_W{1'b0}});

    // Flag gear codes that cannot belong to the current state
    always_comb begin
        legal_s = 1'b0;
        case (state_r)
            S_NEUTRAL:          legal_s = (gear_r == GEAR_N);
            S_DRIVE, S_BRAKING: legal_s = (gear_r >= 4'd1) && (gear_r <= TOP_GEAR);
            S_REVERSE:          legal_s = (gear_r == GEAR_R);
            default:            legal_s = 1'b0;
        endcase
    end

    // Gear FSM with dwell and brake-step counters; all outputs registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_NEUTRAL;
            gear_r        <= GEAR_N;
            segments_r    <= SEG_N;
            shift_event_r <= 1'b0;
            reject_r      <= 1'b0;
            dwell_r       <= {DWELL_W{1'b0}};
            step_r        <= {STEP_W{1'b0}};
            up_prev_r     <= 1'b0;
            down_prev_r   <= 1'b0;
        end else if (ena) begin
            up_prev_r     <= up_lvl_s;
            down_prev_r   <= down_lvl_s;
            segments_r    <= seg_code(gear_r);
            shift_event_r <= 1'b0;
            reject_r      <= 1'b0;
            if (dwell_busy_s) begin
                dwell_r <= dwell_r - DWELL_W'(1);
            end
            if (!legal_s) begin
                state_r <= S_NEUTRAL;
                gear_r  <= GEAR_N;
                step_r  <= {STEP_W{1'b0}};
            end else begin
                case (state_r)
                    S_NEUTRAL: begin
                        if (manual_s) begin
                            if (both_s || dwell_busy_s) begin
                                reject_r <= 1'b1;
                            end else if (up_pulse_s) begin
                                gear_r        <= 4'd1;
                                state_r       <= S_DRIVE;
                                shift_event_r <= 1'b1;
                                dwell_r       <= DWELL_LOAD;
                            end else if (brake_lvl_s) begin
                                gear_r        <= GEAR_R;
                                state_r       <= S_REVERSE;
                                shift_event_r <= 1'b1;
                                dwell_r       <= DWELL_LOAD;
                            end else begin
                                reject_r <= 1'b1;
                            end
                        end
                    end
                    S_DRIVE: begin
                        if (brake_lvl_s) begin
                            state_r  <= S_BRAKING;
                            step_r   <= {STEP_W{1'b0}};
                            reject_r <= manual_s;
                        end else if (manual_s) begin
                            if (both_s || dwell_busy_s) begin
                                reject_r <= 1'b1;
                            end else if (up_pulse_s) begin
                                if (gear_r < TOP_GEAR) begin
                                    gear_r        <= gear_r + 4'd1;
                                    shift_event_r <= 1'b1;
                                    dwell_r       <= DWELL_LOAD;
                                end else begin
                                    reject_r <= 1'b1;
                                end
                            end else begin
                                shift_event_r <= 1'b1;
                                dwell_r       <= DWELL_LOAD;
                                if (gear_r == 4'd1) begin
                                    gear_r  <= GEAR_N;
                                    state_r <= S_NEUTRAL;
                                end else begin
                                    gear_r <= gear_r - 4'd1;
                                end
                            end
                        end
                    end
                    S_BRAKING: begin
                        // A downshift step wins over a coincident manual request so
                        // shift_event and reject never fire together
                        if (!brake_lvl_s) begin
                            state_r  <= S_DRIVE;
                            step_r   <= {STEP_W{1'b0}};
                            reject_r <= manual_s;
                        end else if (step_r == STEP_LAST) begin
                            step_r <= {STEP_W{1'b0}};
                            if (gear_r > 4'd1) begin
                                gear_r        <= gear_r - 4'd1;
                                shift_event_r <= 1'b1;
                                dwell_r       <= DWELL_LOAD;
                            end else begin
                                reject_r <= manual_s;
                            end
                        end else begin
                            step_r   <= step_r + STEP_W'(1);
                            reject_r <= manual_s;
                        end
                    end
                    S_REVERSE: begin
                        if (manual_s) begin
                            if (both_s || dwell_busy_s || !up_pulse_s) begin
                                reject_r <= 1'b1;
                            end else begin
                                gear_r        <= GEAR_N;
                                state_r       <= S_NEUTRAL;
                                shift_event_r <= 1'b1;
                                dwell_r       <= DWELL_LOAD;
                            end
                        end
                    end
                    default: begin
                        state_r <= S_NEUTRAL;
                        gear_r  <= GEAR_N;
                        step_r  <= {STEP_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign gear        = gear_r;
    assign segments    = segments_r;
    assign shift_event = shift_event_r;
    assign reject      = reject_r;

endmodule

// File: tb/tb_gearbox_seq_ctrl.sv
// Scoreboard bench for gearbox_seq_ctrl: a tick-based reference model pushes
// expected shift/reject events, a monitor pops and compares them along with
// gear and display every cycle. Directed scenarios then randomized buttons.
module tb_gearbox_seq_ctrl;

    localparam int NG    = 5;
    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int BSTEP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       shift_up = 1'b0;
    logic       shift_down = 1'b0;
    logic       brake = 1'b0;
    logic [3:0] gear;
    logic [6:0] segments;
    logic       shift_event;
    logic       reject;

    gearbox_seq_ctrl #(
        .NUM_GEARS(NG), .DEBOUNCE_CYC(DB), .HOLD_CYC(HOLD), .BRAKE_STEP_CYC(BSTEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .shift_up(shift_up), .shift_down(shift_down), .brake(brake),
        .gear(gear), .segments(segments), .shift_event(shift_event), .reject(reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] seg_of(input int g);
        case (g)
            0:       return 7'h2B;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            15:      return 7'h2F;
            default: return 7'h7F;
        endcase
    endfunction

    // ---------------- reference model (counts enabled ticks) ----------------
    typedef struct { bit is_shift; int g; } ev_t;
    ev_t exp_q[$];

    bit         model_ok = 1'b0;
    bit         m_tick = 1'b0;
    int         t = 0;
    int         m_gear = 0;
    bit         m_braking = 1'b0;
    int         brake_entry = 0;
    bit         have_change = 1'b0;
    int         last_change = 0;
    logic [6:0] m_seg = 7'h2B;
    logic [2:0] raw_h[$];
    logic [2:0] lp1 = 3'b000, lp2 = 3'b000, nlv;
    bit         up_p, dn_p, brk, manual, both, busy, same;

    task automatic m_set(input int g);
        m_gear = g;
        have_change = 1'b1;
        last_change = t;
        exp_q.push_back('{1'b1, g});
    endtask

    task automatic m_rej();
        exp_q.push_back('{1'b0, m_gear});
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            model_ok = 1'b1; m_tick = 1'b0;
            m_gear = 0; m_braking = 1'b0; have_change = 1'b0;
            m_seg = 7'h2B; lp1 = 3'b000; lp2 = 3'b000;
            raw_h.delete();
            for (int i = 0; i < 8; i++) raw_h.push_back(3'b000);
            exp_q.delete();
        end else if (!ena) begin
            m_tick = 1'b0;
        end else begin
            m_tick = 1'b1;
            t++;
            raw_h.push_front({brake, shift_down, shift_up});
            void'(raw_h.pop_back());
            up_p = lp1[0] & ~lp2[0];
            dn_p = lp1[1] & ~lp2[1];
            brk  = lp1[2];
            // a level flips once the last DB synchronised samples all oppose it
            nlv = lp1;
            for (int b = 0; b < 3; b++) begin
                same = 1'b1;
                for (int j = 2; j < 2 + DB; j++) if (raw_h[j][b] == lp1[b]) same = 1'b0;
                if (same) nlv[b] = ~lp1[b];
            end
            lp2 = lp1; lp1 = nlv;
            m_seg = seg_of(m_gear);
            manual = up_p | dn_p;
            both   = up_p & dn_p;
            busy   = have_change && (t - last_change <= HOLD);
            if (m_gear == 0) begin
                if (manual) begin
                    if (both || busy) m_rej();
                    else if (up_p) m_set(1);
                    else if (brk) m_set(15);
                    else m_rej();
                end
            end else if (m_gear == 15) begin
                if (manual) begin
                    if (both || busy || !up_p) m_rej();
                    else m_set(0);
                end
            end else if (!m_braking) begin
                if (brk) begin
                    m_braking = 1'b1; brake_entry = t;
                    if (manual) m_rej();
                end else if (manual) begin
                    if (both || busy) m_rej();
                    else if (up_p) begin
                        if (m_gear < NG) m_set(m_gear + 1);
                        else m_rej();
                    end else m_set(m_gear - 1);
                end
            end else begin
                if (!brk) begin
                    m_braking = 1'b0;
                    if (manual) m_rej();
                end else if (((t - brake_entry) % BSTEP == 0) && m_gear > 1) m_set(m_gear - 1);
                else if (manual) m_rej();
            end
        end
    end

    // ---------------- monitor ----------------
    ev_t mon_e;
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("gear", gear, m_gear);
            chk("segments", segments, m_seg);
            chk("pulse_exclusive", shift_event & reject, 0);
            if (m_tick) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", {shift_event, reject}, mon_e.is_shift ? 2'b10 : 2'b01);
                    if (mon_e.is_shift) chk("event_gear", gear, mon_e.g);
                end else begin
                    chk("no_event", {shift_event, reject}, 2'b00);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       shift_up = v;
            1:       shift_down = v;
            default: brake = v;
        endcase
    endtask

    task automatic press(input int which, input int hold, input int gap);
        set_btn(which, 1'b1);
        cycles(hold);
        set_btn(which, 1'b0);
        cycles(gap);
    endtask

    initial begin
        cycles(3);
        chk("reset_gear", gear, 0);
        chk("reset_segments", segments, 7'h2B);
        chk("reset_shift_event", shift_event, 0);
        chk("reset_reject", reject, 0);
        rst_n = 1'b1;

        press(0, 10, 14);
        chk("first_up_gear", gear, 1);
        chk("first_up_segments", segments, 7'h79);
        press(0, 3, 12);
        chk("glitch_ignored", gear, 1);

        for (int i = 0; i < 4; i++) press(0, 6, 14);
        chk("up_to_top", gear, 5);
        press(0, 6, 14);
        chk("top_reject", gear, 5);

        shift_down = 1'b1; cycles(3);
        shift_up = 1'b1;   cycles(3);
        shift_down = 1'b0; cycles(3);
        shift_up = 1'b0;   cycles(14);
        chk("dwell_reject", gear, 4);

        brake = 1'b1; cycles(40);
        chk("brake_floor", gear, 1);
        brake = 1'b0; cycles(14);
        press(1, 6, 14);
        chk("down_to_neutral", gear, 0);
        chk("neutral_segments", segments, 7'h2B);

        press(1, 6, 14);
        chk("neutral_down_reject", gear, 0);
        brake = 1'b1; cycles(8);
        press(1, 6, 14);
        chk("reverse_gear", gear, 15);
        chk("reverse_segments", segments, 7'h2F);
        brake = 1'b0; cycles(10);
        press(0, 6, 14);
        chk("reverse_up_neutral", gear, 0);

        shift_up = 1'b1; shift_down = 1'b1; cycles(6);
        shift_up = 1'b0; shift_down = 1'b0; cycles(14);
        chk("both_discarded", gear, 0);

        for (int i = 0; i < 3; i++) press(0, 6, 14);
        brake = 1'b1; cycles(12);
        chk("braking_at_3", gear, 3);
        rst_n = 1'b0; cycles(1);
        chk("reset_mid_brake_gear", gear, 0);
        chk("reset_mid_brake_segments", segments, 7'h2B);
        rst_n = 1'b1; brake = 1'b0; cycles(10);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) shift_up = ~shift_up;
            if ($urandom_range(0, 9) == 0) shift_down = ~shift_down;
            if ($urandom_range(0, 39) == 0) brake = ~brake;
            ena   = ($urandom_range(0, 15) != 0);
            rst_n = ($urandom_range(0, 799) != 0);
            cycles(1);
        end
        shift_up = 1'b0; shift_down = 1'b0; brake = 1'b0; ena = 1'b1; rst_n = 1'b1;
        cycles(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
